// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction and data.
// One transaction in flight; a watchdog forces completion if memory stalls.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic [DATA_WIDTH-1:0] i_read_data,
  output logic                  i_response,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_write_data,
  output logic [DATA_WIDTH-1:0] d_read_data,
  output logic                  d_response,
  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [DATA_WIDTH-1:0] m_write_data,
  input  logic [DATA_WIDTH-1:0] m_read_data,
  input  logic                  m_response,
  output logic                  busy,
  output logic                  timeout_error
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } state_t;

  localparam logic [31:0] TMO_LAST =
    32'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t      state;
  logic        last_d;
  logic        grant_d;
  logic [31:0] counter;

  logic req_i;
  logic req_d;
  logic gnt_i;
  logic gnt_d;
  logic tmo;
  logic done;
  logic [DATA_WIDTH-1:0] rdata;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;
  // on contention the port that did not win last time goes next
  assign gnt_d = req_d & (~req_i | ~last_d);
  assign gnt_i = req_i & ~gnt_d;

  assign tmo = TMO_EN && !m_response &&
               (counter == TMO_LAST);
  assign done = m_response | tmo;
  assign rdata = m_response ? m_read_data
                            : TIMEOUT_DATA;

  // arbitration, memory handshake and response routing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_d        <= 1'b1;
      grant_d       <= 1'b0;
      counter       <= '0;
      busy          <= 1'b0;
      m_read        <= 1'b0;
      m_write       <= 1'b0;
      m_address     <= '0;
      m_write_data  <= '0;
      i_read_data   <= '0;
      d_read_data   <= '0;
      i_response    <= 1'b0;
      d_response    <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      i_response    <= 1'b0;
      d_response    <= 1'b0;
      timeout_error <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            gnt_i: begin
              grant_d      <= 1'b0;
              last_d       <= 1'b0;
              m_write      <= i_write;
              m_read       <= ~i_write;
              m_address    <= i_address;
              m_write_data <= i_write_data;
              counter      <= '0;
              busy         <= 1'b1;
              state        <= BUSY;
            end
            gnt_d: begin
              grant_d      <= 1'b1;
              last_d       <= 1'b1;
              m_write      <= d_write;
              m_read       <= ~d_write;
              m_address    <= d_address;
              m_write_data <= d_write_data;
              counter      <= '0;
              busy         <= 1'b1;
              state        <= BUSY;
            end
            default: ;
          endcase
        end
        BUSY: begin
          if (done) begin
            m_read        <= 1'b0;
            m_write       <= 1'b0;
            counter       <= '0;
            timeout_error <= tmo;
            state         <= RESPOND;
            if (grant_d) begin
              d_response <= 1'b1;
              if (!m_write) d_read_data <= rdata;
            end else begin
              i_response <= 1'b1;
              if (!m_write) i_read_data <= rdata;
            end
          end else begin
            counter <= counter + 32'd1;
          end
        end
        RESPOND: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: random traffic from both ports,
// reference arbitration/data model and a decoupled response monitor.
module tb_memory_port_arbiter;
  localparam int TMO = 8;
  localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic i_read, i_write, i_response;
  logic [31:0] i_address, i_write_data, i_read_data;
  logic d_read, d_write, d_response;
  logic [31:0] d_address, d_write_data, d_read_data;
  logic m_read, m_write, m_response;
  logic [31:0] m_address, m_write_data, m_read_data;
  logic busy, timeout_error;

  memory_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_DATA(TMO_DATA)
  ) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_write(i_write),
    .i_address(i_address), .i_write_data(i_write_data),
    .i_read_data(i_read_data), .i_response(i_response),
    .d_read(d_read), .d_write(d_write),
    .d_address(d_address), .d_write_data(d_write_data),
    .d_read_data(d_read_data), .d_response(d_response),
    .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_write_data(m_write_data),
    .m_read_data(m_read_data), .m_response(m_response),
    .busy(busy), .timeout_error(timeout_error)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tmo;
  } txn_t;

  txn_t qi[$];
  txn_t qd[$];
  int vectors = 0;
  int fails = 0;
  bit pend_i = 0;
  bit pend_d = 0;
  bit model_last_d = 1;
  logic [31:0] last_rd [2];
  bit in_reset = 1;
  bit hold_mem = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic bit drops(input logic [31:0] a);
    return a[3:0] == 4'hF;
  endfunction

  task automatic drive(input int p, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      i_read = rd; i_write = wr; i_address = a; i_write_data = wd;
    end else begin
      d_read = rd; d_write = wr; d_address = a; d_write_data = wd;
    end
  endtask

  // issue one request, hold it until the port sees its response
  task automatic do_txn(input int p, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gap);
    txn_t t;
    bit got;
    repeat (gap) @(negedge clk);
    t.wr = wr;
    t.addr = a;
    t.wdata = wd;
    t.tmo = drops(a);
    if (wr) t.rdata = last_rd[p];
    else if (t.tmo) t.rdata = TMO_DATA;
    else t.rdata = mem_fn(a);
    last_rd[p] = t.rdata;
    if (p == 0) begin qi.push_back(t); pend_i = 1; end
    else begin qd.push_back(t); pend_d = 1; end
    drive(p, rd, wr, a, wd);
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = (p == 0) ? i_response : d_response;
    end
    if (!got) begin
      vectors++; fails++;
      $display("FAIL resp_wait port %0d: no response in 100 cycles, required one", p);
    end
    drive(p, 1'b0, 1'b0, $urandom, $urandom);
    if (p == 0) pend_i = 0; else pend_d = 0;
  endtask

  task automatic rand_port(input int p, input int n);
    int r;
    logic [31:0] a, wd;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 3);
      a = $urandom;
      wd = $urandom;
      do_txn(p, r != 2, r >= 2, a, wd, $urandom_range(1, 4));
    end
  endtask

  task automatic check_zero(input string name);
    logic [135:0] v;
    v = {i_read_data, d_read_data, m_address, m_write_data,
         i_response, d_response, m_read, m_write, busy,
         timeout_error, 2'b00};
    vectors++;
    if (v !== '0 || m_write_data !== '0) begin
      fails++;
      $display("FAIL %s: outputs=%h, required all zero", name, v);
    end
  endtask

  // memory model: random latency, never answers drop addresses,
  // and throws stray response pulses while the arbiter is idle
  int lat;
  bit started = 0;
  bit responded = 0;
  initial begin
    m_response = 0;
    m_read_data = 0;
    forever begin
      @(negedge clk);
      m_response = 0;
      m_read_data = $urandom;
      if (m_read | m_write) begin
        if (!started) begin
          started = 1;
          lat = $urandom_range(0, 4);
        end
        if (!responded && !hold_mem && !drops(m_address)) begin
          if (lat == 0) begin
            m_response = 1;
            m_read_data = mem_fn(m_address);
            responded = 1;
          end else lat--;
        end
      end else begin
        started = 0;
        responded = 0;
        if (!busy && reset && $urandom_range(0, 3) == 0)
          m_response = 1;
      end
    end
  end

  // monitor: checks grants against round-robin rule, responses
  // against the queued expectations
  int cyc = 0;
  int grant_cyc = 0;
  int granted = -1;
  int win;
  int rp;
  bit prev_act = 0;
  bit act;
  txn_t t_m;
  txn_t t_r;
  logic [31:0] snap_a, snap_wd, got_rd;
  logic snap_r, snap_w;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (in_reset) begin
        prev_act = 0;
        continue;
      end
      act = m_read | m_write;
      if (act && !prev_act) begin
        vectors++;
        if (!pend_i && !pend_d) begin
          fails++;
          $display("FAIL grant_noreq: m_read=%b m_write=%b, required idle",
                   m_read, m_write);
        end else begin
          win = (pend_i && pend_d) ? (model_last_d ? 0 : 1)
                                   : (pend_i ? 0 : 1);
          if ((win == 0 && qi.size() == 0) ||
              (win == 1 && qd.size() == 0)) begin
            fails++;
            $display("FAIL grant_q port %0d: empty queue", win);
          end else begin
            t_m = (win == 0) ? qi[0] : qd[0];
            if (m_write !== t_m.wr || m_read !== !t_m.wr ||
                m_address !== t_m.addr ||
                (t_m.wr && m_write_data !== t_m.wdata)) begin
              fails++;
              $display("FAIL grant port %0d: got r%b w%b a=%h wd=%h, required w%b a=%h wd=%h",
                       win, m_read, m_write, m_address, m_write_data,
                       t_m.wr, t_m.addr, t_m.wdata);
            end
          end
          model_last_d = (win == 1);
          granted = win;
          grant_cyc = cyc;
        end
        snap_a = m_address; snap_wd = m_write_data;
        snap_r = m_read; snap_w = m_write;
      end else if (act) begin
        vectors++;
        if (m_address !== snap_a || m_write_data !== snap_wd ||
            m_read !== snap_r || m_write !== snap_w) begin
          fails++;
          $display("FAIL m_stable: a=%h wd=%h, required a=%h wd=%h",
                   m_address, m_write_data, snap_a, snap_wd);
        end
      end
      prev_act = act;
      if (i_response | d_response) begin
        rp = i_response ? 0 : 1;
        vectors++;
        if ((rp == 0 && qi.size() == 0) ||
            (rp == 1 && qd.size() == 0)) begin
          fails++;
          $display("FAIL resp_q port %0d: unexpected response", rp);
        end else begin
          t_r = (rp == 0) ? qi.pop_front() : qd.pop_front();
          got_rd = (rp == 0) ? i_read_data : d_read_data;
          if ((i_response && d_response) || rp != granted || act ||
              got_rd !== t_r.rdata || timeout_error !== t_r.tmo) begin
            fails++;
            $display("FAIL resp port %0d: rd=%h tmo=%b gnt=%0d, required rd=%h tmo=%b gnt=%0d",
                     rp, got_rd, timeout_error, granted,
                     t_r.rdata, t_r.tmo, rp);
          end
          if (t_r.tmo) begin
            vectors++;
            if (cyc - grant_cyc != TMO) begin
              fails++;
              $display("FAIL tmo_lat: %0d busy cycles, required %0d",
                       cyc - grant_cyc, TMO);
            end
          end
        end
      end else if (timeout_error) begin
        vectors++; fails++;
        $display("FAIL tmo_pulse: timeout_error=1 without response, required 0");
      end
    end
  end

  txn_t tr;
  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1;
    in_reset = 0;
    @(negedge clk);
    // simultaneous first requests: instruction wins after reset
    fork
      do_txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 1);
      do_txn(1, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 1);
    join
    do_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1);
    // continuous contention, alternating grants
    fork
      for (int k = 0; k < 3; k++)
        do_txn(0, 1'b1, 1'b0, 32'h1000 + 32'(k * 4), 32'h0, 1);
      for (int k = 0; k < 3; k++)
        do_txn(1, 1'b1, 1'b0, 32'h2000 + 32'(k * 4), 32'h0, 1);
    join
    do_txn(1, 1'b1, 1'b0, 32'h30F, 32'h0, 1);
    do_txn(0, 1'b1, 1'b1, 32'h44, 32'h0BADC0DE, 1);
    do_txn(0, 1'b1, 1'b0, 32'h48, 32'h0, 1);
    do_txn(0, 1'b0, 1'b1, 32'h4C, 32'h1111, 1);
    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join
    // async reset while a transaction is outstanding
    @(negedge clk);
    hold_mem = 1;
    tr.wr = 0; tr.addr = 32'h80; tr.wdata = 0;
    tr.rdata = mem_fn(32'h80); tr.tmo = 0;
    qi.push_back(tr);
    pend_i = 1;
    drive(0, 1'b1, 1'b0, 32'h80, 32'h0);
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || m_read !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: busy=%b m_read=%b, required 1 1",
               busy, m_read);
    end
    #2;
    reset = 0;
    in_reset = 1;
    #1;
    check_zero("async_reset");
    qi.delete();
    qd.delete();
    pend_i = 0;
    drive(0, 1'b0, 1'b0, '0, '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    model_last_d = 1;
    hold_mem = 0;
    @(negedge clk);
    reset = 1;
    in_reset = 0;
    fork
      do_txn(0, 1'b1, 1'b0, 32'h90, 32'h0, 1);
      do_txn(1, 1'b1, 1'b0, 32'h94, 32'h0, 1);
    join
    repeat (5) @(negedge clk);
    vectors++;
    if (qi.size() != 0 || qd.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d left, required 0/0",
               qi.size(), qd.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
